// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack port, core-facing valid/ready
// port and the redirect request.
interface ifetch_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output mem_req, mem_addr, instr, instr_pc, instr_valid,
        input  mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, instr, instr_pc, instr_valid,
        output mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: PC sequencing, single-outstanding memory reads,
// prefetch FIFO toward the core, and redirect flush with drain of a stale request.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic          clock,
    input logic          reset,
    ifetch_unit_if.master bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state;
    logic [31:0]        pc;
    logic [31:0]        fifo_word [FIFO_DEPTH];
    logic [31:0]        fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_after;
    logic               pop;
    logic               push;
    logic [31:0]        new_pc;

    assign pop         = (count != '0) && bus.instr_ready;
    assign push        = (state == FETCH) && bus.mem_ack;
    assign count_after = count + CNT_W'(push) - CNT_W'(pop);
    assign new_pc      = bus.redirect_pc & ~32'd3;

    assign bus.instr_valid = (count != '0);
    assign bus.instr       = (count != '0) ? fifo_word[rd_ptr] : NOP;
    assign bus.instr_pc    = (count != '0) ? fifo_pc[rd_ptr]   : 32'd0;

    // Redirect wins over push/pop; a request already on the bus is never abandoned
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= RESET_PC;
            pc           <= RESET_PC;
            count        <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
        end else if (bus.redirect) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            pc     <= new_pc;
            case (state)
                FETCH: begin
                    if (bus.mem_ack) begin
                        bus.mem_addr <= new_pc;
                    end else begin
                        state <= DRAIN;
                    end
                end
                DRAIN:   state <= DRAIN;
                default: state <= IDLE;
            endcase
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                fifo_word[wr_ptr] <= bus.mem_rdata;
                fifo_pc[wr_ptr]   <= pc;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            count <= count_after;
            case (state)
                IDLE: begin
                    if (count < CNT_W'(FIFO_DEPTH)) begin
                        state        <= FETCH;
                        bus.mem_req  <= 1'b1;
                        bus.mem_addr <= pc;
                    end
                end
                FETCH: begin
                    if (bus.mem_ack) begin
                        pc <= pc + 32'd4;
                        if (count_after < CNT_W'(FIFO_DEPTH)) begin
                            bus.mem_addr <= pc + 32'd4;
                        end else begin
                            state       <= IDLE;
                            bus.mem_req <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // Stale data is dropped; restart at the redirect target
                    if (bus.mem_ack) begin
                        if (count_after < CNT_W'(FIFO_DEPTH)) begin
                            state        <= FETCH;
                            bus.mem_addr <= pc;
                        end else begin
                            state       <= IDLE;
                            bus.mem_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.mem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: queue-level reference of the prefetch stream checked every
// cycle, plus directed scenarios with literal expectations.
module tb_ifetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] w;
    } ent_t;

    logic clk;
    logic rst;
    logic ack_en;
    logic bad_data;
    int   ack_wait;
    int   wait_cnt;

    int n_tests;
    int n_fail;

    ent_t        q[$];
    logic [31:0] m_pc;
    logic        draining;
    logic [31:0] drain_addr;
    logic        model_ok;
    logic [31:0] dlv_pc[$];
    logic [31:0] dlv_w[$];

    ifetch_unit_if bus();

    ifetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    // Memory responder: ack after ack_wait stalled cycles of a held request
    always_comb begin
        bus.mem_ack   = bus.mem_req && ack_en && (wait_cnt >= ack_wait);
        bus.mem_rdata = bad_data ? 32'hDEAD_BEEF : mem_fn(bus.mem_addr);
    end

    always_ff @(posedge clk) begin
        if (rst || !bus.mem_req || bus.mem_ack) wait_cnt <= 0;
        else                                    wait_cnt <= wait_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare against the reference at negedge, advance it, return at posedge+1
    task automatic cycle();
        logic exp_v;
        @(negedge clk);
        if (model_ok && !rst) begin
            exp_v = (q.size() != 0);
            chk("instr_valid", 32'(bus.instr_valid), 32'(exp_v));
            chk("instr", bus.instr, exp_v ? q[0].w : NOP);
            chk("instr_pc", bus.instr_pc, exp_v ? q[0].pc : 32'd0);
            if (bus.mem_req) begin
                chk("mem_addr", bus.mem_addr, draining ? drain_addr : m_pc);
                if (!draining) chk("req_room", 32'(q.size() < 4), 32'd1);
            end
            if (bus.instr_valid && bus.instr_ready) begin
                dlv_pc.push_back(bus.instr_pc);
                dlv_w.push_back(bus.instr);
            end
        end
        if (rst) begin
            q.delete();
            m_pc     = 32'h0;
            draining = 1'b0;
            model_ok = 1'b1;
        end else if (bus.redirect) begin
            if (bus.mem_req && !bus.mem_ack && !draining) begin
                draining   = 1'b1;
                drain_addr = bus.mem_addr;
            end
            q.delete();
            m_pc = bus.redirect_pc & ~32'd3;
        end else begin
            if (q.size() != 0 && bus.instr_ready) void'(q.pop_front());
            if (bus.mem_req && bus.mem_ack) begin
                if (draining) begin
                    draining = 1'b0;
                end else begin
                    q.push_back({m_pc, mem_fn(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.instr_ready = 1'b0;
        bad_data        = 1'b0;
        ack_wait        = 0;
        cycle();
        cycle();
        rst = 1'b0;
        dlv_pc.delete();
        dlv_w.delete();
    endtask

    initial begin
        int n;
        n_tests  = 0;
        n_fail   = 0;
        model_ok = 1'b0;
        draining = 1'b0;
        m_pc     = 32'h0;
        drain_addr = 32'h0;
        ack_en   = 1'b1;

        // Reset state
        do_reset();
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);

        // 1: streaming at one word per cycle
        bus.instr_ready = 1'b1;
        cycle();
        for (int i = 0; i < 6; i++) begin
            chk("t1_req", 32'(bus.mem_req), 32'd1);
            chk("t1_addr", bus.mem_addr, 32'(4 * i));
            if (i >= 1) begin
                chk("t1_valid", 32'(bus.instr_valid), 32'd1);
                chk("t1_pc", bus.instr_pc, 32'(4 * (i - 1)));
            end
            cycle();
        end

        // 2: core stalled -> FIFO fills to four, requests stop until a pop
        do_reset();
        for (int i = 0; i < 8; i++) cycle();
        chk("t2_req_off", 32'(bus.mem_req), 32'd0);
        chk("t2_head", bus.instr_pc, 32'h0);
        chk("t2_word", bus.instr, 32'h5A5A_0F0F);
        bus.instr_ready = 1'b1;
        cycle();
        bus.instr_ready = 1'b0;
        chk("t2_pop_head", bus.instr_pc, 32'h4);
        chk("t2_still_off", 32'(bus.mem_req), 32'd0);
        cycle();
        chk("t2_req_10", 32'(bus.mem_req), 32'd1);
        chk("t2_addr_10", bus.mem_addr, 32'h10);
        cycle();
        cycle();

        // 3: three wait states before ack
        do_reset();
        ack_wait = 3;
        cycle();
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold_req", 32'(bus.mem_req), 32'd1);
            chk("t3_hold_addr", bus.mem_addr, 32'h0);
            chk("t3_no_ack", 32'(bus.mem_ack), 32'd0);
            chk("t3_empty", 32'(bus.instr_valid), 32'd0);
            cycle();
        end
        chk("t3_ack", 32'(bus.mem_ack), 32'd1);
        cycle();
        chk("t3_pushed", 32'(bus.instr_valid), 32'd1);
        chk("t3_next_addr", bus.mem_addr, 32'h4);
        cycle();

        // 4: redirect with three words buffered, ack in the same cycle
        do_reset();
        for (int i = 0; i < 4; i++) cycle();
        chk("t4_three", bus.instr_pc, 32'h0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        cycle();
        bus.redirect = 1'b0;
        chk("t4_flushed", 32'(bus.instr_valid), 32'd0);
        chk("t4_req", 32'(bus.mem_req), 32'd1);
        chk("t4_addr", bus.mem_addr, 32'h100);
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        chk("t4_dlv_n", 32'(dlv_pc.size() >= 2), 32'd1);
        chk("t4_first_pc", dlv_pc[0], 32'h100);
        chk("t4_first_w", dlv_w[0], 32'h5B5A_0F0F);

        // 5: redirect mid-request -> late stale data is discarded
        do_reset();
        bus.instr_ready = 1'b1;
        ack_wait = 5;
        cycle();
        cycle();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0100;
        cycle();
        bus.redirect = 1'b0;
        chk("t5_drain_req", 32'(bus.mem_req), 32'd1);
        chk("t5_drain_addr", bus.mem_addr, 32'h0);
        bad_data = 1'b1;
        n = 0;
        while (!bus.mem_ack && n < 10) begin
            cycle();
            n++;
        end
        chk("t5_ack_seen", 32'(bus.mem_ack), 32'd1);
        cycle();
        bad_data = 1'b0;
        ack_wait = 0;
        chk("t5_refetch", bus.mem_addr, 32'h100);
        chk("t5_no_stale", 32'(bus.instr_valid), 32'd0);
        for (int i = 0; i < 4; i++) cycle();
        chk("t5_first_pc", (dlv_pc.size() != 0) ? dlv_pc[0] : 32'hFFFF_FFFF, 32'h100);
        n = 0;
        foreach (dlv_w[i]) if (dlv_w[i] == 32'hDEAD_BEEF) n++;
        chk("t5_deadbeef", 32'(n), 32'd0);

        // 6: PC wraps past the top of the address space
        do_reset();
        bus.instr_ready = 1'b1;
        cycle();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        cycle();
        bus.redirect = 1'b0;
        chk("t6_addr_top", bus.mem_addr, 32'hFFFF_FFFC);
        dlv_pc.delete();
        dlv_w.delete();
        cycle();
        chk("t6_addr_wrap", bus.mem_addr, 32'h0);
        for (int i = 0; i < 3; i++) cycle();
        chk("t6_dlv_n", 32'(dlv_pc.size() >= 2), 32'd1);
        chk("t6_pc0", dlv_pc[0], 32'hFFFF_FFFC);
        chk("t6_w0", dlv_w[0], 32'hA5A6_F0F0);
        chk("t6_pc1", dlv_pc[1], 32'h0);
        chk("t6_w1", dlv_w[1], 32'h5A5A_0F0F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
